// File: rtl/pc_gen.sv
// pc_gen: fetch program counter for the IF stage.
// Advances the PC by INC and takes exception/branch/jump redirects in that
// priority order. A redirect seen while stalled is captured and applied on
// the first write-enabled cycle. Misaligned targets raise a sticky flag.
module pc_gen #(
   parameter int unsigned            WIDTH      = 32,
   parameter logic [WIDTH-1:0]       RESET_VEC  = '0,
   parameter int unsigned            INC        = 4,
   parameter int unsigned            ALIGN_BITS = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             pc_write_i,
   input  logic             exc_valid_i,
   input  logic [WIDTH-1:0] exc_target_i,
   input  logic             br_valid_i,
   input  logic [WIDTH-1:0] br_target_i,
   input  logic             jmp_valid_i,
   input  logic [WIDTH-1:0] jmp_target_i,
   output logic [WIDTH-1:0] pc_o,
   output logic [WIDTH-1:0] pc_plus_o,
   output logic             valid_o,
   output logic             flush_o,
   output logic             pending_o,
   output logic             misalign_o
);

   // Low target bits that must be zero; empty when ALIGN_BITS is 0.
   localparam logic [WIDTH-1:0] ALIGN_MASK = ~({WIDTH{1'b1}} << ALIGN_BITS);
   localparam logic [WIDTH-1:0] INC_W      = WIDTH'(INC);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic             valid_q, valid_d;
   logic             flush_q, flush_d;
   logic             misalign_q, misalign_d;
   logic             pend_q, pend_d;
   logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
   logic [1:0]       pend_pri_q, pend_pri_d;

   logic             sel_valid;
   logic [WIDTH-1:0] sel_tgt;
   logic [1:0]       sel_pri;
   logic             take_sel;

   // Pick the highest-priority redirect; priority 1 is the strongest.
   always_comb begin
      sel_tgt = '0;
      sel_pri = 2'd0;
      if (exc_valid_i) begin
         sel_tgt = exc_target_i;
         sel_pri = 2'd1;
      end else if (br_valid_i) begin
         sel_tgt = br_target_i;
         sel_pri = 2'd2;
      end else if (jmp_valid_i) begin
         sel_tgt = jmp_target_i;
         sel_pri = 2'd3;
      end
      sel_valid = exc_valid_i | br_valid_i | jmp_valid_i;
      // An incoming redirect beats a captured one of equal or lower priority.
      take_sel  = sel_valid & (~pend_q | (sel_pri <= pend_pri_q));
   end

   // Next-state logic: boot handshake, sequential advance, redirect capture/apply.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      valid_d    = valid_q;
      flush_d    = 1'b0;
      pend_d     = pend_q;
      pend_tgt_d = pend_tgt_q;
      pend_pri_d = pend_pri_q;
      misalign_d = misalign_q | (sel_valid & (|(sel_tgt & ALIGN_MASK)));

      case (state_q)
         BOOT: begin
            valid_d = 1'b1;
            state_d = RUN;
            if (take_sel) begin
               pend_d     = 1'b1;
               pend_tgt_d = sel_tgt;
               pend_pri_d = sel_pri;
            end
         end
         RUN, HOLD: begin
            if (pc_write_i) begin
               if (take_sel) begin
                  pc_d    = sel_tgt;
                  flush_d = 1'b1;
               end else if (pend_q) begin
                  pc_d    = pend_tgt_q;
                  flush_d = 1'b1;
               end else begin
                  pc_d    = pc_q + INC_W;
               end
               pend_d  = 1'b0;
               state_d = RUN;
            end else begin
               if (take_sel) begin
                  pend_d     = 1'b1;
                  pend_tgt_d = sel_tgt;
                  pend_pri_d = sel_pri;
               end
               if (sel_valid) begin
                  state_d = HOLD;
               end
            end
         end
         default: begin
            state_d = BOOT;
         end
      endcase
   end

   // State and output registers; reset discards any captured redirect at once.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= BOOT;
         pc_q       <= RESET_VEC;
         valid_q    <= 1'b0;
         flush_q    <= 1'b0;
         misalign_q <= 1'b0;
         pend_q     <= 1'b0;
         pend_tgt_q <= '0;
         pend_pri_q <= 2'd0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         valid_q    <= valid_d;
         flush_q    <= flush_d;
         misalign_q <= misalign_d;
         pend_q     <= pend_d;
         pend_tgt_q <= pend_tgt_d;
         pend_pri_q <= pend_pri_d;
      end
   end

   assign pc_o       = pc_q;
   assign pc_plus_o  = pc_q + INC_W;
   assign valid_o    = valid_q;
   assign flush_o    = flush_q;
   assign pending_o  = pend_q;
   assign misalign_o = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: 32-bit default instance plus an 8-bit wrap instance.
module tb_pc_gen;

   logic        clk;
   logic        rst;
   logic        pc_write;
   logic        exc_v, br_v, jmp_v;
   logic [31:0] exc_t, br_t, jmp_t;
   logic [31:0] pc, pc_plus;
   logic        valid, flush, pending, misalign;

   logic [7:0]  pc8, pc8_plus;
   logic        valid8, flush8, pending8, misalign8;

   int unsigned total = 0;
   int unsigned bad   = 0;

   pc_gen u_dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .pc_write_i   (pc_write),
      .exc_valid_i  (exc_v),
      .exc_target_i (exc_t),
      .br_valid_i   (br_v),
      .br_target_i  (br_t),
      .jmp_valid_i  (jmp_v),
      .jmp_target_i (jmp_t),
      .pc_o         (pc),
      .pc_plus_o    (pc_plus),
      .valid_o      (valid),
      .flush_o      (flush),
      .pending_o    (pending),
      .misalign_o   (misalign)
   );

   pc_gen #(
      .WIDTH     (8),
      .RESET_VEC (8'hF8)
   ) u_dut8 (
      .clk_i        (clk),
      .rst_i        (rst),
      .pc_write_i   (1'b1),
      .exc_valid_i  (1'b0),
      .exc_target_i (8'h00),
      .br_valid_i   (1'b0),
      .br_target_i  (8'h00),
      .jmp_valid_i  (1'b0),
      .jmp_target_i (8'h00),
      .pc_o         (pc8),
      .pc_plus_o    (pc8_plus),
      .valid_o      (valid8),
      .flush_o      (flush8),
      .pending_o    (pending8),
      .misalign_o   (misalign8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; pc_write = 1'b1;
      exc_v = 1'b0; br_v = 1'b0; jmp_v = 1'b0;
      exc_t = '0; br_t = '0; jmp_t = '0;
      step(); step();

      // Reset state
      check("rst_pc", pc, 32'h0);
      check("rst_valid", {31'b0, valid}, 32'h0);
      check("rst_flush", {31'b0, flush}, 32'h0);
      check("rst_pending", {31'b0, pending}, 32'h0);
      check("rst_misalign", {31'b0, misalign}, 32'h0);
      check("rst_pc_plus", pc_plus, 32'h4);
      check("rst_pc8", {24'b0, pc8}, 32'hF8);

      // Release: BOOT holds RESET_VEC one more cycle
      rst = 1'b1;
      step();
      check("boot_pc", pc, 32'h0);
      check("boot_valid", {31'b0, valid}, 32'h1);
      check("boot_pc8", {24'b0, pc8}, 32'hF8);
      step();
      check("seq_pc4", pc, 32'h4);
      check("seq_pc8_fc", {24'b0, pc8}, 32'hFC);
      check("seq_pc8_plus_wrap", {24'b0, pc8_plus}, 32'h00);
      step();
      check("seq_pc8", pc, 32'h8);
      check("seq_pc8_wrap", {24'b0, pc8}, 32'h00);
      step();
      check("seq_pc12", pc, 32'hC);
      step();
      check("seq_pc16", pc, 32'h10);

      // Branch and jump together: branch wins
      br_v = 1'b1; br_t = 32'h100; jmp_v = 1'b1; jmp_t = 32'h200;
      step();
      br_v = 1'b0; jmp_v = 1'b0;
      check("br_pc", pc, 32'h100);
      check("br_flush", {31'b0, flush}, 32'h1);
      step();
      check("br_next_pc", pc, 32'h104);
      check("br_next_flush", {31'b0, flush}, 32'h0);

      // Stall: jump captured, then replaced by exception
      pc_write = 1'b0; jmp_v = 1'b1; jmp_t = 32'h40;
      step();
      jmp_v = 1'b0;
      check("st1_pending", {31'b0, pending}, 32'h1);
      check("st1_pc", pc, 32'h104);
      exc_v = 1'b1; exc_t = 32'h80;
      step();
      exc_v = 1'b0;
      check("st2_pc", pc, 32'h104);
      step();
      check("st3_pc", pc, 32'h104);
      check("st3_pending", {31'b0, pending}, 32'h1);
      check("st3_flush", {31'b0, flush}, 32'h0);
      pc_write = 1'b1;
      step();
      check("st_rel_pc", pc, 32'h80);
      check("st_rel_flush", {31'b0, flush}, 32'h1);
      check("st_rel_pending", {31'b0, pending}, 32'h0);
      step();
      check("st_after_pc", pc, 32'h84);

      // Stall: exception then lower-priority branch does not replace it
      pc_write = 1'b0; exc_v = 1'b1; exc_t = 32'h80;
      step();
      exc_v = 1'b0; br_v = 1'b1; br_t = 32'h300;
      step();
      br_v = 1'b0; pc_write = 1'b1;
      step();
      check("prio_pc", pc, 32'h80);
      check("prio_flush", {31'b0, flush}, 32'h1);
      check("prio_misalign", {31'b0, misalign}, 32'h0);

      // Misaligned branch, then stall with pending jump, then async reset
      br_v = 1'b1; br_t = 32'h102;
      step();
      br_v = 1'b0;
      check("mis_pc", pc, 32'h102);
      check("mis_flag", {31'b0, misalign}, 32'h1);
      pc_write = 1'b0; jmp_v = 1'b1; jmp_t = 32'h40;
      step();
      jmp_v = 1'b0;
      check("mis_hold_pending", {31'b0, pending}, 32'h1);
      check("mis_hold_flag", {31'b0, misalign}, 32'h1);
      check("mis_hold_pc", pc, 32'h102);
      #3;
      rst = 1'b0;
      #1;
      check("async_pc", pc, 32'h0);
      check("async_pending", {31'b0, pending}, 32'h0);
      check("async_misalign", {31'b0, misalign}, 32'h0);
      check("async_valid", {31'b0, valid}, 32'h0);

      // Redirect arriving during BOOT is captured and applied next
      pc_write = 1'b1;
      step();
      rst = 1'b1; exc_v = 1'b1; exc_t = 32'h20;
      step();
      exc_v = 1'b0;
      check("bootcap_pc", pc, 32'h0);
      check("bootcap_pending", {31'b0, pending}, 32'h1);
      check("bootcap_valid", {31'b0, valid}, 32'h1);
      step();
      check("bootcap_apply_pc", pc, 32'h20);
      check("bootcap_apply_flush", {31'b0, flush}, 32'h1);
      check("bootcap_apply_pending", {31'b0, pending}, 32'h0);
      step();
      check("bootcap_next_pc", pc, 32'h24);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
